aes_ctr_sequencer: RTL and testbench

Controller that sequences an iterative AES-128 block core in CTR mode for the AES-CTR peripheral.
- Loads and expands the key once, then accepts 128-bit data blocks on a valid/ready stream.
- For each block: builds the counter block {nonce, ctr}, pulses the core's next, XORs the keystream with the data and returns the result on an output stream.
- Sits between the AXI4-Lite register file (which supplies key/nonce/counter/control) and the AES core.

---
 rtl/aes_ctr_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_sequencer.sv
// AES-128 CTR-mode sequencer: drives an iterative AES core and XORs its keystream onto a block stream.
// Optional sticky counter-wrap error and stall enabled by defining AES_CTR_SEQ_WRAP_ERR_EN.
module aes_ctr_sequencer #(
  parameter int unsigned CTR_W = 64,
  localparam int unsigned NONCE_W = 128 - CTR_W
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [127:0]       cfg_key,
  input  logic [NONCE_W-1:0] cfg_nonce,
  input  logic [CTR_W-1:0]   cfg_ctr,
  input  logic               cfg_load,
  output logic               busy,
  output logic               key_ok,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [127:0]       s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [127:0]       m_data,
  output logic [127:0]       core_key,
  output logic [127:0]       core_block,
  output logic               core_init,
  output logic               core_next,
  input  logic               core_ready,
  input  logic [127:0]       core_result,
  input  logic               core_valid,
`ifdef AES_CTR_SEQ_WRAP_ERR_EN
  output logic               ctr_wrap_err,
`endif
  output logic [CTR_W-1:0]   ctr_value
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_WAIT_INIT, ST_READY, ST_NEXT, ST_WAIT_RES, ST_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       key_q, key_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [127:0]       data_q, data_d;
  logic [127:0]       m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               s_ready_q, s_ready_d;
  logic               key_ok_q, key_ok_d;
  logic               busy_q, busy_d;
  logic               core_init_q, core_init_d;
  logic               core_next_q, core_next_d;
  logic               first_q, first_d;
  logic               res_take;
  logic               stall_d;

  // The core drops ready/valid one cycle after a command, so the first wait cycle is ignored.
  assign res_take = (state_q == ST_WAIT_RES) && !first_q && core_valid;

`ifdef AES_CTR_SEQ_WRAP_ERR_EN
  logic wrap_err_q, wrap_err_d;

  always_comb begin
    wrap_err_d = wrap_err_q;
    if (cfg_load) begin
      wrap_err_d = 1'b0;
    end else if (res_take && (&ctr_q)) begin
      wrap_err_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wrap_err_q <= 1'b0;
    end else begin
      wrap_err_q <= wrap_err_d;
    end
  end

  assign stall_d      = wrap_err_d;
  assign ctr_wrap_err = wrap_err_q;
`else
  assign stall_d = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      data_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      key_ok_q    <= 1'b0;
      busy_q      <= 1'b0;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      data_q      <= data_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      s_ready_q   <= s_ready_d;
      key_ok_q    <= key_ok_d;
      busy_q      <= busy_d;
      core_init_q <= core_init_d;
      core_next_q <= core_next_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    ctr_d       = ctr_q;
    data_d      = data_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    key_ok_d    = key_ok_q;
    core_init_d = 1'b0;
    core_next_d = 1'b0;
    first_d     = 1'b0;

    // A config load aborts whatever is in flight, from any state.
    if (cfg_load) begin
      key_d     = cfg_key;
      nonce_d   = cfg_nonce;
      ctr_d     = cfg_ctr;
      m_valid_d = 1'b0;
      key_ok_d  = 1'b0;
      state_d   = ST_INIT;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_INIT: begin
          if (core_ready) begin
            core_init_d = 1'b1;
            first_d     = 1'b1;
            state_d     = ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          if (!first_q && core_ready) begin
            key_ok_d = 1'b1;
            state_d  = ST_READY;
          end
        end
        ST_READY: begin
          if (s_valid && s_ready) begin
            data_d      = s_data;
            core_next_d = 1'b1;
            state_d     = ST_NEXT;
          end
        end
        ST_NEXT: begin
          first_d = 1'b1;
          state_d = ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          if (res_take) begin
            m_data_d  = data_q ^ core_result;
            m_valid_d = 1'b1;
            ctr_d     = ctr_q + CTR_W'(1);
            state_d   = ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid_d = 1'b0;
            state_d   = ST_READY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d    = !((state_d == ST_IDLE) || (state_d == ST_READY));
    s_ready_d = (state_d == ST_READY) && !stall_d;
  end

  // cfg_load must win over a same-cycle input handshake.
  assign s_ready    = s_ready_q & ~cfg_load;
  assign busy       = busy_q;
  assign key_ok     = key_ok_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign core_key   = key_q;
  assign core_block = {nonce_q, ctr_q};
  assign core_init  = core_init_q;
  assign core_next  = core_next_q;
  assign ctr_value  = ctr_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Scoreboard bench for aes_ctr_sequencer with a behavioural AES-128 core and CTR reference model.
module tb_aes_ctr_sequencer;
  localparam int unsigned CTR_W = 64;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic         aresetn, cfg_load, s_valid, m_ready;
  logic [127:0] cfg_key, s_data;
  logic [63:0]  cfg_nonce, cfg_ctr;
  logic         busy, key_ok, s_ready, m_valid, core_init, core_next;
  logic [127:0] m_data, core_key, core_block;
  logic [63:0]  ctr_value;
  logic         core_ready = 1'b1;
  logic         core_valid = 1'b0;
  logic [127:0] core_result = '0;
`ifdef AES_CTR_SEQ_WRAP_ERR_EN
  logic         ctr_wrap_err;
`endif

  aes_ctr_sequencer #(.CTR_W(CTR_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
    .cfg_ctr(cfg_ctr), .cfg_load(cfg_load), .busy(busy), .key_ok(key_ok),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .core_key(core_key), .core_block(core_block),
    .core_init(core_init), .core_next(core_next), .core_ready(core_ready),
    .core_result(core_result), .core_valid(core_valid),
`ifdef AES_CTR_SEQ_WRAP_ERR_EN
    .ctr_wrap_err(ctr_wrap_err),
`endif
    .ctr_value(ctr_value)
  );

  int total = 0, bad = 0;
  int init_cnt = 0, next_cnt = 0, hs_cnt = 0, loads = 0, accepted = 0;
  int mr_mode = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_q [$];
  logic [127:0] mkey;
  logic [63:0]  mnonce, mctr;

  localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [63:0]  N  = 64'hf0f1f2f3f4f5f6f7;
  localparam logic [63:0]  C  = 64'hf8f9fafbfcfdfeff;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] E1 = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] E2 = 128'h9806f66b7970fdff8617187bb9fffdff;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // GF(2^8) helpers and a plain AES-128 encryptor
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Behavioural iterative core: ready drops after a command, result level-valid after a random latency
  int core_cnt = 0;
  bit pend_next = 1'b0;
  always @(posedge aclk) begin
    if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_ready <= 1'b1;
        if (pend_next) core_valid <= 1'b1;
      end
    end else if (core_ready && core_init) begin
      core_ready <= 1'b0;
      core_valid <= 1'b0;
      pend_next  <= 1'b0;
      core_cnt   <= int'($urandom_range(2, 10));
    end else if (core_ready && core_next) begin
      core_ready  <= 1'b0;
      core_valid  <= 1'b0;
      pend_next   <= 1'b1;
      core_result <= aes_enc(core_key, core_block);
      core_cnt    <= int'($urandom_range(2, 12));
    end
  end

  // Output monitor and core-command monitor
  always @(negedge aclk) begin
    logic [127:0] e;
    if (core_init) init_cnt++;
    if (core_next) next_cnt++;
    if (core_init || core_next)
      chk("core_cmd_legal", 128'({core_ready, core_init & core_next}), 128'(2'b10));
    if (m_valid && m_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("m_unexpected", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("m_data", m_data, e);
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_load(input logic [127:0] k, input logic [63:0] n, input logic [63:0] c,
                         input bit with_svalid);
    int i;
    cfg_key = k; cfg_nonce = n; cfg_ctr = c; cfg_load = 1'b1;
    if (with_svalid) begin
      s_valid = 1'b1;
      s_data  = rnd128();
      #1;
      chk("s_ready_vs_load", 128'(s_ready), 128'(0));
    end
    tick();
    cfg_load = 1'b0; s_valid = 1'b0;
    mkey = k; mnonce = n; mctr = c;
    exp_q.delete();
    loads++;
    for (i = 0; i < 500 && !key_ok; i++) tick();
    chk("key_ok", 128'(key_ok), 128'(1));
  endtask

  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int i;
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (i = 0; i < 500 && !done; i++) begin
      if (s_ready) begin
        exp_q.push_back(e);
        accepted++;
        done = 1'b1;
      end
      tick();
    end
    s_valid = 1'b0;
    if (!done) chk("s_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic send_m(input logic [127:0] d);
    send(d, d ^ aes_enc(mkey, {mnonce, mctr}));
    mctr = mctr + 64'd1;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 3000 && exp_q.size() > 0; i++) tick();
    chk("drain", 128'(exp_q.size()), 128'(0));
    tick();
  endtask

  task automatic wait_core_busy();
    int i;
    for (i = 0; i < 200 && core_ready; i++) tick();
    chk("core_busy_seen", 128'(core_ready), 128'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_key_ok"}, 128'(key_ok), 128'(0));
    chk({tag, "_s_ready"}, 128'(s_ready), 128'(0));
    chk({tag, "_m_valid"}, 128'(m_valid), 128'(0));
    chk({tag, "_m_data"}, m_data, 128'(0));
    chk({tag, "_core_key"}, core_key, 128'(0));
    chk({tag, "_core_block"}, core_block, 128'(0));
    chk({tag, "_core_cmd"}, 128'({core_init, core_next}), 128'(0));
    chk({tag, "_ctr_value"}, 128'(ctr_value), 128'(0));
`ifdef AES_CTR_SEQ_WRAP_ERR_EN
    chk({tag, "_wrap_err"}, 128'(ctr_wrap_err), 128'(0));
`endif
  endtask

  initial begin
    int nc, hs, ic;
    logic [127:0] md;
    logic [7:0] r;
    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      for (int k = 0; k < 254; k++) r = gm(r, 8'(x));
      sb[x] = r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
    end
    aresetn = 1'b0; cfg_load = 1'b0; s_valid = 1'b0;
    cfg_key = '0; cfg_nonce = '0; cfg_ctr = '0; s_data = '0;
    repeat (3) tick();
    chk_reset_outputs("rst0");
    aresetn = 1'b1;
    tick();

    // Known-answer block 1 then block 2 streamed
    do_load(K, N, C, 1'b0);
    send(P1, E1);
    drain();
    chk("ctr_after_b1", 128'(ctr_value), 128'(64'hf8f9fafbfcfdff00));
    send(P2, E2);
    drain();
    do_load(K, N, C, 1'b0);
    nc = next_cnt;
    send(P1, E1);
    send(P2, E2);
    drain();
    chk("next_per_block_stream", 128'(next_cnt - nc), 128'(2));
    chk("ctr_after_stream", 128'(ctr_value), 128'(64'hf8f9fafbfcfdff01));
    mctr = 64'hf8f9fafbfcfdff01;

    // Backpressure
    mr_mode = 1;
    tick();
    send_m(rnd128());
    for (int i = 0; i < 200 && !m_valid; i++) tick();
    chk("bp_m_valid", 128'(m_valid), 128'(1));
    md = m_data; nc = next_cnt; hs = hs_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_m_valid_hold", 128'(m_valid), 128'(1));
      chk("bp_m_data_stable", m_data, md);
      chk("bp_s_ready", 128'(s_ready), 128'(0));
    end
    chk("bp_no_next", 128'(next_cnt), 128'(nc));
    mr_mode = 0;
    drain();
    chk("bp_single_xfer", 128'(hs_cnt - hs), 128'(1));

    // Abort during WAIT_RES
    send_m(rnd128());
    wait_core_busy();
    hs = hs_cnt; ic = init_cnt;
    do_load(K, N, 64'h0123456789abcdef, 1'b0);
    repeat (30) tick();
    chk("abort_no_output", 128'(hs_cnt), 128'(hs));
    chk("abort_init_once", 128'(init_cnt - ic), 128'(1));
    send_m(rnd128());
    drain();

    // Randomized configs, data and backpressure
    mr_mode = 2;
    for (int l = 0; l < 3; l++) begin
      do_load(rnd128(), {$urandom, $urandom}, {$urandom, $urandom}, l == 1);
      for (int b = 0; b < 6; b++) send_m(rnd128());
      drain();
    end
    mr_mode = 0;

    // Counter wrap
    do_load(rnd128(), 64'hdeadbeef01234567, 64'hffffffffffffffff, 1'b0);
    send_m(rnd128());
    drain();
    chk("wrap_ctr", 128'(ctr_value), 128'(0));
    chk("wrap_nonce", 128'(core_block[127:64]), 128'(64'hdeadbeef01234567));
`ifdef AES_CTR_SEQ_WRAP_ERR_EN
    chk("wrap_err_set", 128'(ctr_wrap_err), 128'(1));
    s_valid = 1'b1;
    s_data  = rnd128();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wrap_stall", 128'(s_ready), 128'(0));
    end
    s_valid = 1'b0;
    do_load(K, N, C, 1'b0);
    chk("wrap_err_clear", 128'(ctr_wrap_err), 128'(0));
`else
    send_m(rnd128());
    drain();
    chk("wrap_continue_ctr", 128'(ctr_value), 128'(1));
`endif

    // Reset mid-WAIT_RES, then key reload
    send_m(rnd128());
    wait_core_busy();
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    tick();
    chk_reset_outputs("rst_mid_edge");
    exp_q.delete();
    aresetn = 1'b1;
    tick();
    do_load(K, N, C, 1'b0);
    send(P1, E1);
    drain();

    chk("next_per_block_total", 128'(next_cnt), 128'(accepted));
    chk("init_per_load_total", 128'(init_cnt), 128'(loads));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
